// File: rtl/score_controller.sv
// -----------------------------------------------------------------------------
// score_controller
//
// Match sequencer for a two-player paddle game. It tracks both scores, asks the
// ball logic to serve, enables play, freezes the field for HOLD_CYCLES after
// every point, and declares a winner once a player reaches WIN_SCORE.
//
// Parameters
//   WIN_SCORE    points needed to win (1..15)
//   HOLD_CYCLES  freeze length after each point, in clock cycles (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   start        level, request a new match (honoured in IDLE and OVER only)
//   point_p1     one-cycle pulse, player 1 scored (honoured in PLAY only)
//   point_p2     one-cycle pulse, player 2 scored (honoured in PLAY only)
//   serve_ack    ball logic accepted the serve request
//   score1       player 1 score, binary 0..15
//   score2       player 2 score, binary 0..15
//   serve_req    serve request, high for the whole SERVE state
//   serve_dir    0 = serve toward player 1, 1 = toward player 2
//   play_en      high only in PLAY
//   game_over    high only in OVER
//   winner       00 none, 01 player 1, 10 player 2
//   dbg_state_o  current FSM state, for observation only
//
// Serve handshake: serve_req is asserted for every cycle spent in SERVE. A
// serve_ack sampled high on a rising edge while serve_req is high completes
// the transfer; the FSM is in PLAY after that edge and serve_req is low.
// -----------------------------------------------------------------------------
module score_controller #(
    parameter int WIN_SCORE   = 11,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       serve_ack,
    output logic [4:0] score1,
    output logic [4:0] score2,
    output logic       serve_req,
    output logic       serve_dir,
    output logic       play_en,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] dbg_state_o
);

    // Counter only has to hold HOLD_CYCLES-1.
    localparam int              CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [4:0]      SCORE_MAX = 5'd15;
    localparam logic [4:0]      WIN_VAL   = 5'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_HOLD  = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      score1_q, score1_d;
    logic [4:0]      score2_q, score2_d;
    logic            serve_dir_q, serve_dir_d;
    logic [1:0]      winner_q, winner_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    // Who scored the point currently being held: 0 = player 1, 1 = player 2.
    logic            scorer_q, scorer_d;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v >= SCORE_MAX) ? v : v + 5'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        hold_cnt_d  = hold_cnt_q;
        scorer_d    = scorer_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d     = S_SERVE;
                    score1_d    = 5'd0;
                    score2_d    = 5'd0;
                    winner_d    = 2'b00;
                    serve_dir_d = 1'b0;
                end
            end

            S_SERVE: begin
                if (serve_ack) begin
                    state_d = S_PLAY;
                end
            end

            S_PLAY: begin
                // Simultaneous pulses are a glitch and change nothing.
                if (point_p1 && !point_p2) begin
                    score1_d    = sat_inc(score1_q);
                    serve_dir_d = 1'b1;
                    scorer_d    = 1'b0;
                    hold_cnt_d  = HOLD_LOAD;
                    state_d     = S_HOLD;
                end else if (point_p2 && !point_p1) begin
                    score2_d    = sat_inc(score2_q);
                    serve_dir_d = 1'b0;
                    scorer_d    = 1'b1;
                    hold_cnt_d  = HOLD_LOAD;
                    state_d     = S_HOLD;
                end
            end

            S_HOLD: begin
                if (hold_cnt_q == CW'(0)) begin
                    // Scores were already updated on HOLD entry.
                    if ((scorer_q ? score2_q : score1_q) == WIN_VAL) begin
                        state_d  = S_OVER;
                        winner_d = scorer_q ? 2'b10 : 2'b01;
                    end else begin
                        state_d = S_SERVE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            score1_q    <= 5'd0;
            score2_q    <= 5'd0;
            serve_dir_q <= 1'b0;
            winner_q    <= 2'b00;
            hold_cnt_q  <= '0;
            scorer_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
            hold_cnt_q  <= hold_cnt_d;
            scorer_q    <= scorer_d;
        end
    end

    assign score1      = score1_q;
    assign score2      = score2_q;
    assign serve_dir   = serve_dir_q;
    assign winner      = winner_q;
    assign serve_req   = (state_q == S_SERVE);
    assign play_en     = (state_q == S_PLAY);
    assign game_over   = (state_q == S_OVER);
    assign dbg_state_o = state_q;

endmodule
